alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, sets the operand width; the result is WIDTH+1 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  a command is presented.
REQ-005 cmd_ready  output  1  the block accepts a command; a handshake occurs on an edge where cmd_valid && cmd_ready.
REQ-006 cmd_a  input  WIDTH  operand A, unsigned.
REQ-007 cmd_b  input  WIDTH  operand B, unsigned.
REQ-008 cmd_sel  input  3  opcode: 000 pass A, 001 add, 010 sub, 011 div, 100 mod, 101 shl1, 110 shr1, 111 compare A>B.
REQ-009 rsp_valid  output  1  a result is presented.
REQ-010 rsp_ready  input  1  the consumer accepts the result.
REQ-011 rsp_data  output  WIDTH+1  result.
REQ-012 rsp_err  output  1  the result came from div or mod with B=0.

Function
REQ-013 The block shall implement an FSM with states IDLE, DIV and RESP.
REQ-014 cmd_ready shall be 1 only in IDLE with rst low; it shall be 0 in DIV and RESP, giving one command in flight at a time.
REQ-015 cmd_a, cmd_b and cmd_sel shall be sampled only on the handshake edge; later input changes shall have no effect on the operation in flight.
REQ-016 For a non-div/mod opcode, the block shall register the result on the handshake edge, enter RESP, and raise rsp_valid 1 cycle after acceptance.
REQ-017 Arithmetic rules:
- pass = {0,A}.
- add = A+B, with the carry in bit WIDTH.
- sub = (A-B) mod 2^(WIDTH+1).
- shl1 = A<<1 at WIDTH+1 bits.
- shr1 = {0,A>>1}.
- compare = 1 if A>B (unsigned), else 0.
REQ-018 For div/mod with B!=0, the handshake edge shall load a restoring divider and enter DIV.
REQ-019 The divider shall produce one quotient bit per cycle.
REQ-020 The block shall enter RESP exactly WIDTH edges after acceptance.
REQ-021 The div result shall be the quotient and the mod result the remainder, each zero-extended to WIDTH+1 bits.
REQ-022 For div/mod with B=0, the block shall go directly to RESP with rsp_data=0 and rsp_err=1, latency 1.
REQ-023 rsp_err shall be 0 for all other results.
REQ-024 In RESP, rsp_valid=1, and rsp_data/rsp_err shall remain stable until an edge with rsp_ready=1; that edge returns the FSM to IDLE and clears rsp_valid.
REQ-025 Maximum throughput shall be one command per 2 cycles for non-div ops and one per WIDTH+1 cycles for div/mod.
REQ-026 rsp_ready asserted outside RESP shall be ignored.

Reset
REQ-027 rst high shall immediately force the FSM to IDLE, rsp_valid=0, rsp_data=0 and rsp_err=0, and shall clear the divider registers.
REQ-028 cmd_ready shall be 0 while rst is high.
REQ-029 A reset asserted in DIV or RESP shall discard the operation in flight; no response for it shall ever be produced.
REQ-030 The first handshake shall be possible on the first rising edge after rst deasserts.

Configuration
REQ-031 With macro ALU_SEQ_OP_COUNT_EN defined, the block shall add output op_count (16 bits), incremented on each response handshake, saturating at 0xFFFF and cleared by rst.
REQ-032 Without ALU_SEQ_OP_COUNT_EN, the op_count port and its logic shall be absent; all other behaviour shall be identical.

Verification (WIDTH=8)
REQ-033 Add: A=200, B=100, sel=001 -> rsp_data=0x12C and rsp_err=0, with rsp_valid 1 cycle after acceptance.
REQ-034 Div/mod:
- A=200, B=7, sel=011 -> rsp_data=0x01C, rsp_valid exactly 8 cycles after acceptance.
- sel=100 -> rsp_data=0x004.
REQ-035 Div by zero: A=5, B=0, sel=011 -> rsp_data=0, rsp_err=1, latency 1.
REQ-036 Backpressure: A=0x81, B=0x01, sel=010 with rsp_ready held low 5 cycles -> rsp_data=0x080 held stable, cmd_ready=0, and a second command is not accepted until the response handshake.
REQ-037 Reset mid-op: rst pulsed 3 cycles into a div -> rsp_valid=0 immediately and no response appears. After reset, sel=101 with A=0x81 -> 0x102; sel=111 with A=3, B=5 -> 0.
REQ-038 ALU_SEQ_OP_COUNT_EN defined: after 3 completed responses op_count=3; a reset then gives op_count=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with a valid/ready command port and a valid/ready
// response port. Only one command is in flight at a time. Single-cycle
// operations answer one cycle after acceptance. div/mod use a restoring
// divider and answer WIDTH cycles after acceptance.
//
// Optional build macro: ALU_SEQ_OP_COUNT_EN adds a saturating 16-bit op_count
// output that counts response handshakes.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_a, cmd_b          unsigned operands (WIDTH bits)
//   cmd_sel               000 pass, 001 add, 010 sub, 011 div, 100 mod,
//                         101 shl1, 110 shr1, 111 A>B
//   rsp_valid/rsp_ready   response handshake
//   rsp_data              result (WIDTH+1 bits)
//   rsp_err               div/mod with B=0
//   op_count              (ALU_SEQ_OP_COUNT_EN only) completed responses
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// DIV   | restoring divider iterating, one quotient bit per cycle
// RESP  | result presented, waiting for rsp_ready
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_data,
`ifdef ALU_SEQ_OP_COUNT_EN
  output logic [15:0]      op_count,
`endif
  output logic             rsp_err
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_MOD  = 3'b100;
  localparam logic [2:0] OP_SHL  = 3'b101;
  localparam logic [2:0] OP_SHR  = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DIV, RESP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] div_rem, div_q, div_b;
  logic             div_mod;
  logic [CNT_W-1:0] div_cnt;

  logic             hs, is_divmod, b_zero;
  logic [WIDTH:0]   alu_res;
  logic [WIDTH-1:0] step_rem, step_q, step_b, rem_nxt, q_nxt, diff;
  logic [WIDTH:0]   shifted;
  logic             ge;

  assign cmd_ready = (state == IDLE) && !rst;
  assign rsp_valid = (state == RESP);
  assign hs        = cmd_valid && cmd_ready;
  assign is_divmod = (cmd_sel == OP_DIV) || (cmd_sel == OP_MOD);
  assign b_zero    = (cmd_b == '0);

  always_comb begin
    alu_res = '0;
    case (cmd_sel)
      OP_PASS: alu_res = {1'b0, cmd_a};
      OP_ADD:  alu_res = {1'b0, cmd_a} + {1'b0, cmd_b};
      OP_SUB:  alu_res = {1'b0, cmd_a} - {1'b0, cmd_b};
      OP_SHL:  alu_res = {cmd_a, 1'b0};
      OP_SHR:  alu_res = {2'b0, cmd_a[WIDTH-1:1]};
      OP_CMP:  alu_res = {{WIDTH{1'b0}}, (cmd_a > cmd_b)};
      default: alu_res = '0;
    endcase
  end

  // One restoring step. The first step runs on the handshake edge straight
  // from the command operands, so the remaining WIDTH-1 steps finish exactly
  // WIDTH cycles after acceptance. The partial remainder is always < B, so
  // the W-bit modular difference is exact whenever ge is set.
  always_comb begin
    step_rem = (state == IDLE) ? '0    : div_rem;
    step_q   = (state == IDLE) ? cmd_a : div_q;
    step_b   = (state == IDLE) ? cmd_b : div_b;
    shifted  = {step_rem, step_q[WIDTH-1]};
    ge       = shifted[WIDTH] || (shifted[WIDTH-1:0] >= step_b);
    diff     = shifted[WIDTH-1:0] - step_b;
    rem_nxt  = ge ? diff : shifted[WIDTH-1:0];
    q_nxt    = {step_q[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (hs) state_nxt = (is_divmod && !b_zero) ? DIV : RESP;
      DIV:  if (div_cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_rem  <= '0;
      div_q    <= '0;
      div_b    <= '0;
      div_mod  <= 1'b0;
      div_cnt  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (hs) begin
      div_rem <= rem_nxt;
      div_q   <= q_nxt;
      div_b   <= cmd_b;
      div_mod <= (cmd_sel == OP_MOD);
      div_cnt <= CNT_W'(WIDTH - 2);
      if (!(is_divmod && !b_zero)) begin
        rsp_data <= is_divmod ? '0 : alu_res;
        rsp_err  <= is_divmod;
      end
    end else if (state == DIV) begin
      div_rem <= rem_nxt;
      div_q   <= q_nxt;
      if (div_cnt == '0) begin
        rsp_data <= div_mod ? {1'b0, rem_nxt} : {1'b0, q_nxt};
        rsp_err  <= 1'b0;
      end else begin
        div_cnt <= div_cnt - 1'b1;
      end
    end
  end

`ifdef ALU_SEQ_OP_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      op_count <= '0;
    else if ((state == RESP) && rsp_ready && (op_count != 16'hFFFF))
      op_count <= op_count + 16'd1;
  end
`endif

endmodule
